// File: rtl/vga_draw_rect_if.sv
// Signal bundle between a rectangle-plot controller and the vga_draw_rect
// rasteriser. The master drives coordinates, size, colour and requests; the
// slave returns the pixel stream that feeds vga_adapter plus status.
interface vga_draw_rect_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SIZE_W   = 5
);
  // Request side
  logic [X_W-1:0]      pos_in;
  logic                store_pos;
  logic [SIZE_W-1:0]   rect_w;
  logic [SIZE_W-1:0]   rect_h;
  logic [COLOUR_W-1:0] colour_in;
  logic                plot_req;
  logic                clear_req;

  // Pixel stream and status
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                writeEn;
  logic                busy;
  logic                done;

  modport master (
    output pos_in, store_pos, rect_w, rect_h, colour_in, plot_req, clear_req,
    input  x, y, colour, writeEn, busy, done
  );

  modport slave (
    input  pos_in, store_pos, rect_w, rect_h, colour_in, plot_req, clear_req,
    output x, y, colour, writeEn, busy, done
  );
endinterface

// File: rtl/vga_draw_rect.sv
// Rectangle rasteriser for vga_adapter. X and Y are loaded alternately from a
// shared position bus; a plot request snapshots position, size and colour and
// walks the rectangle one pixel per clock, suppressing writeEn for pixels that
// fall off the visible screen. A clear request paints the whole screen with
// CLEAR_COLOUR. Every output is registered.
module vga_draw_rect #(
  parameter int                  X_W          = 8,
  parameter int                  Y_W          = 7,
  parameter int                  COLOUR_W     = 3,
  parameter int                  SIZE_W       = 5,
  parameter int                  SCREEN_W     = 160,
  parameter int                  SCREEN_H     = 120,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
  input logic            clock,
  input logic            reset,
  vga_draw_rect_if.slave bus
);

  // Zero-extension needed to add a size offset to a one-bit-wider coordinate.
  localparam int PAD_X = X_W + 1 - SIZE_W;
  localparam int PAD_Y = Y_W + 1 - SIZE_W;

  localparam logic [X_W-1:0] LAST_CX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] LAST_CY = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   LIMIT_X = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]   LIMIT_Y = (Y_W + 1)'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;

  // Position load path
  logic           r_store_d;
  logic           r_ptr_y;
  logic [X_W-1:0] r_x_reg;
  logic [Y_W-1:0] r_y_reg;
  logic           w_store_rise;

  // Snapshot of the active rectangle
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [SIZE_W-1:0]   r_w;
  logic [SIZE_W-1:0]   r_h;
  logic [COLOUR_W-1:0] r_col;

  // Raster offsets (draw) and screen counters (clear)
  logic [SIZE_W-1:0] r_dx;
  logic [SIZE_W-1:0] r_dy;
  logic [X_W-1:0]    r_cx;
  logic [Y_W-1:0]    r_cy;

  // Registered outputs
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_write_en;
  logic                r_busy;
  logic                r_done;

  // Next-step decode
  logic              w_dx_end;
  logic              w_dy_end;
  logic [SIZE_W-1:0] w_dx_next;
  logic [SIZE_W-1:0] w_dy_next;
  logic              w_cx_end;
  logic              w_cy_end;
  logic [X_W-1:0]    w_cx_next;
  logic [Y_W-1:0]    w_cy_next;
  logic [X_W:0]      w_px_wide;
  logic [Y_W:0]      w_py_wide;
  logic              w_px_on;
  logic              w_size_zero;

  assign w_store_rise = bus.store_pos & ~r_store_d;
  assign w_size_zero  = (bus.rect_w == '0) || (bus.rect_h == '0);

  // Capture store_pos edges and load X, then Y, alternately.
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update from pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_store_d <= 1'b0;
      r_ptr_y   <= 1'b0;
      r_x_reg   <= '0;
      r_y_reg   <= '0;
    end else begin
      r_store_d <= bus.store_pos;
      if (w_store_rise) begin
        if (r_ptr_y) begin
          r_y_reg <= bus.pos_in[Y_W-1:0];
        end else begin
          r_x_reg <= bus.pos_in;
        end
        r_ptr_y <= ~r_ptr_y;
      end
    end
  end

  // Work out the next raster position and whether that pixel is visible.
  // NOTE: each combinational output receives a value on every path so no
  // latch is inferred.
  always_comb begin
    w_dx_end  = (r_dx == r_w - 1'b1);
    w_dy_end  = (r_dy == r_h - 1'b1);
    w_dx_next = w_dx_end ? '0 : r_dx + 1'b1;
    w_dy_next = w_dx_end ? r_dy + 1'b1 : r_dy;

    w_cx_end  = (r_cx == LAST_CX);
    w_cy_end  = (r_cy == LAST_CY);
    w_cx_next = w_cx_end ? '0 : r_cx + 1'b1;
    w_cy_next = w_cx_end ? r_cy + 1'b1 : r_cy;

    // In IDLE the first pixel comes straight from the position registers,
    // because the snapshot is only being written on this same edge.
    if (r_state == S_IDLE) begin
      w_px_wide = {1'b0, r_x_reg};
      w_py_wide = {1'b0, r_y_reg};
    end else begin
      w_px_wide = {1'b0, r_x0} + {{PAD_X{1'b0}}, w_dx_next};
      w_py_wide = {1'b0, r_y0} + {{PAD_Y{1'b0}}, w_dy_next};
    end

    w_px_on = (w_px_wide < LIMIT_X) && (w_py_wide < LIMIT_Y);
  end

  // Operation sequencer: accepts requests in IDLE, emits one pixel per clock
  // in DRAW/CLEAR, and holds a one-cycle DONE before returning to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_col      <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_write_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_write_en <= 1'b0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          if (bus.clear_req) begin
            r_state    <= S_CLEAR;
            r_cx       <= '0;
            r_cy       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= CLEAR_COLOUR;
            r_write_en <= 1'b1;
            r_busy     <= 1'b1;
          end else if (bus.plot_req) begin
            r_x0   <= r_x_reg;
            r_y0   <= r_y_reg;
            r_w    <= bus.rect_w;
            r_h    <= bus.rect_h;
            r_col  <= bus.colour_in;
            r_dx   <= '0;
            r_dy   <= '0;
            r_busy <= 1'b1;
            if (w_size_zero) begin
              // Degenerate rectangle: no pixels, straight to completion.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_DRAW;
              r_x        <= w_px_wide[X_W-1:0];
              r_y        <= w_py_wide[Y_W-1:0];
              r_colour   <= bus.colour_in;
              r_write_en <= w_px_on;
            end
          end
        end

        S_DRAW: begin
          if (w_dx_end && w_dy_end) begin
            r_state    <= S_DONE;
            r_write_en <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_dx       <= w_dx_next;
            r_dy       <= w_dy_next;
            r_x        <= w_px_wide[X_W-1:0];
            r_y        <= w_py_wide[Y_W-1:0];
            r_colour   <= r_col;
            r_write_en <= w_px_on;
          end
        end

        S_CLEAR: begin
          if (w_cx_end && w_cy_end) begin
            r_state    <= S_DONE;
            r_write_en <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_cx       <= w_cx_next;
            r_cy       <= w_cy_next;
            r_x        <= w_cx_next;
            r_y        <= w_cy_next;
            r_colour   <= CLEAR_COLOUR;
            r_write_en <= 1'b1;
          end
        end

        S_DONE: begin
          r_state    <= S_IDLE;
          r_write_en <= 1'b0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_write_en <= 1'b0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.colour  = r_colour;
  assign bus.writeEn = r_write_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_vga_draw_rect.sv
// Scoreboard bench for vga_draw_rect. Stimulus computes the expected cycle
// stream of each operation from the rectangle/screen rules and queues it; a
// negedge monitor pops one entry per busy cycle and compares.
module tb_vga_draw_rect;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  typedef struct packed {
    logic       done;
    logic       we;
    logic [2:0] col;
    logic [6:0] y;
    logic [7:0] x;
  } rec_t;

  logic clk;
  logic reset;

  vga_draw_rect_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .SIZE_W(5)) bus_if ();

  vga_draw_rect #(
    .X_W(8), .Y_W(7), .COLOUR_W(3), .SIZE_W(5),
    .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .CLEAR_COLOUR(3'd0)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t sb[$];
  logic in_op = 1'b0;

  // Bench-side view of the position registers.
  int m_x = 0;
  int m_y = 0;
  int m_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream for a rectangle: W*H pixel cycles then one done cycle.
  task automatic push_rect(input int x0, input int y0, input int w, input int h, input int col);
    rec_t r;
    for (int dy = 0; dy < h; dy++) begin
      for (int dx = 0; dx < w; dx++) begin
        int wx;
        int wy;
        wx     = x0 + dx;
        wy     = y0 + dy;
        r.done = 1'b0;
        r.we   = (wx < SCR_W) && (wy < SCR_H);
        r.col  = col[2:0];
        r.x    = wx[7:0];
        r.y    = wy[6:0];
        sb.push_back(r);
      end
    end
    r      = '0;
    r.done = 1'b1;
    sb.push_back(r);
  endtask

  task automatic push_clear();
    rec_t r;
    for (int cy = 0; cy < SCR_H; cy++) begin
      for (int cx = 0; cx < SCR_W; cx++) begin
        r.done = 1'b0;
        r.we   = 1'b1;
        r.col  = 3'd0;
        r.x    = cx[7:0];
        r.y    = cy[6:0];
        sb.push_back(r);
      end
    end
    r      = '0;
    r.done = 1'b1;
    sb.push_back(r);
  endtask

  // Monitor: one scoreboard entry per busy cycle; idle cycles must be quiet.
  always @(negedge clk) begin
    rec_t e;
    rec_t got;
    if (reset) begin
      sb.delete();
      in_op = 1'b0;
    end else if (bus_if.busy) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e        = sb.pop_front();
        got.done = bus_if.done;
        got.we   = bus_if.writeEn;
        got.col  = bus_if.colour;
        got.y    = bus_if.y;
        got.x    = bus_if.x;
        if (e.done) begin
          check("done_cycle", {30'd0, got.done, got.we}, {30'd0, e.done, e.we});
          in_op = 1'b0;
        end else begin
          check("pixel", 32'(got), 32'(e));
          in_op = 1'b1;
        end
      end
    end else begin
      check("idle_quiet", {29'd0, bus_if.writeEn, bus_if.done, in_op}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int v);
    bus_if.pos_in    = v[7:0];
    bus_if.store_pos = 1'b1;
    tick();
    bus_if.store_pos = 1'b0;
    tick();
    if (m_ptr == 0) m_x = v & 255;
    else            m_y = v & 127;
    m_ptr ^= 1;
  endtask

  // Waits for the done pulse; done_at is the cycle index after acceptance.
  task automatic wait_op(output int done_at);
    done_at = -1;
    for (int k = 1; k <= 25000; k++) begin
      @(negedge clk);
      if (k == 1) check("first_cycle_busy", 32'(bus_if.busy), 32'd1);
      if (bus_if.done) begin
        done_at = k;
        break;
      end
    end
    check("op_completed", 32'(done_at > 0), 32'd1);
    tick();
  endtask

  task automatic plot(input int w, input int h, input int col, output int done_at);
    bus_if.rect_w    = w[4:0];
    bus_if.rect_h    = h[4:0];
    bus_if.colour_in = col[2:0];
    push_rect(m_x, m_y, w, h, col);
    bus_if.plot_req  = 1'b1;
    tick();
    bus_if.plot_req  = 1'b0;
    wait_op(done_at);
  endtask

  initial begin
    int d;
    int d1;
    int d2;
    reset             = 1'b1;
    bus_if.pos_in     = '0;
    bus_if.store_pos  = 1'b0;
    bus_if.rect_w     = '0;
    bus_if.rect_h     = '0;
    bus_if.colour_in  = '0;
    bus_if.plot_req   = 1'b0;
    bus_if.clear_req  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_x",       32'(bus_if.x),       32'd0);
    check("rst_y",       32'(bus_if.y),       32'd0);
    check("rst_colour",  32'(bus_if.colour),  32'd0);
    check("rst_writeEn", 32'(bus_if.writeEn), 32'd0);
    check("rst_busy",    32'(bus_if.busy),    32'd0);
    check("rst_done",    32'(bus_if.done),    32'd0);
    #1 reset = 1'b0;
    tick();

    // Basic 4x4 square
    store(10);
    store(20);
    plot(4, 4, 5, d);
    check("done_latency_4x4", d, 17);

    // Bottom-right corner clipping
    store(158);
    store(118);
    plot(4, 4, 2, d);

    // Clear wins over plot
    bus_if.rect_w    = 5'd3;
    bus_if.rect_h    = 5'd3;
    bus_if.clear_req = 1'b1;
    bus_if.plot_req  = 1'b1;
    push_clear();
    tick();
    bus_if.clear_req = 1'b0;
    bus_if.plot_req  = 1'b0;
    wait_op(d);
    check("done_latency_clear", d, SCR_W * SCR_H + 1);

    // Zero width
    plot(0, 5, 3, d);
    check("done_latency_w0", d, 1);

    // Mid-draw load, then reset at pixel 7
    store(30);
    store(40);
    bus_if.rect_w    = 5'd5;
    bus_if.rect_h    = 5'd3;
    bus_if.colour_in = 3'd6;
    push_rect(m_x, m_y, 5, 3, 6);
    bus_if.plot_req  = 1'b1;
    tick();
    bus_if.plot_req  = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) check("mid_first_busy", 32'(bus_if.busy), 32'd1);
      if (k == 2) begin
        bus_if.pos_in    = 8'd50;
        bus_if.store_pos = 1'b1;
      end
      if (k == 3) bus_if.store_pos = 1'b0;
    end
    #1 reset = 1'b1;
    m_x = 0;
    m_y = 0;
    m_ptr = 0;
    @(negedge clk);
    check("rst_mid_writeEn", 32'(bus_if.writeEn), 32'd0);
    check("rst_mid_busy",    32'(bus_if.busy),    32'd0);
    check("rst_mid_done",    32'(bus_if.done),    32'd0);
    #1 reset = 1'b0;
    tick();
    // Position registers cleared: 1x1 lands on (0,0)
    plot(1, 1, 7, d);
    // Load pointer back on X
    store(33);
    plot(1, 1, 4, d);

    // Hold-to-repeat
    bus_if.rect_w    = 5'd2;
    bus_if.rect_h    = 5'd1;
    bus_if.colour_in = 3'd1;
    push_rect(m_x, m_y, 2, 1, 1);
    push_rect(m_x, m_y, 2, 1, 1);
    d1 = -1;
    d2 = -1;
    bus_if.plot_req = 1'b1;
    tick();
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus_if.done) begin
        if (d1 < 0) d1 = k;
        else begin
          d2 = k;
          bus_if.plot_req = 1'b0;
          break;
        end
      end
    end
    bus_if.plot_req = 1'b0;
    check("repeat_done1", d1, 3);
    check("repeat_done2", d2, 7);
    tick();
    tick();

    // Randomised rectangles
    for (int i = 0; i < 10; i++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) store($urandom_range(0, 255));
      plot($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7), d);
    end

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
